// File: rtl/pos_if.sv
// Button/hold inputs and published position bytes of pos_tracker.
// The tracker uses the slave modport; its driver uses the master modport.
interface pos_if;
  logic [4:0] btn_in;
  logic       hold;
  logic [7:0] x_pos;
  logic [7:0] y_pos;
  logic [7:0] status;
  logic       update;

  modport master (output btn_in, hold, input x_pos, y_pos, status, update);
  modport slave  (input btn_in, hold, output x_pos, y_pos, status, update);
endinterface

// File: rtl/pos_tracker.sv
// Debounced 5-button cursor tracker publishing x_pos/y_pos/status as one coherent snapshot.
// Optional auto-repeat of held direction buttons is enabled by defining POS_AUTOREPEAT_EN.
module pos_tracker #(
  parameter int unsigned DB_CYCLES  = 1000,
  parameter int unsigned X_MAX      = 159,
  parameter int unsigned Y_MAX      = 119,
  parameter int unsigned X_INIT     = 80,
  parameter int unsigned Y_INIT     = 60,
  parameter int unsigned STEP       = 1,
  parameter int unsigned RPT_DELAY  = 5000,
  parameter int unsigned RPT_PERIOD = 2000
) (
  input  logic clk,
  input  logic rst_n,
  pos_if.slave bus
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [7:0] X_INIT_B = 8'(X_INIT);
  localparam logic [7:0] Y_INIT_B = 8'(Y_INIT);
  localparam logic [7:0] X_MAX_B  = 8'(X_MAX);
  localparam logic [7:0] Y_MAX_B  = 8'(Y_MAX);
  localparam logic [8:0] STEP_9   = 9'(STEP);
  localparam logic [7:0] ST_RST   = {1'b0,
                                     1'(Y_INIT == 0 || Y_INIT == Y_MAX),
                                     1'(X_INIT == 0 || X_INIT == X_MAX),
                                     5'b0};

  if (DB_CYCLES < 2 || X_MAX > 255 || Y_MAX > 255 || X_INIT > X_MAX || Y_INIT > Y_MAX ||
      STEP < 1 || STEP > 255 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
    $error("pos_tracker: illegal parameter combination");
  end

  // ---------------- synchroniser + debounce ----------------
  logic [4:0]      sync1, sync2, dbc;
  logic [DB_W-1:0] db_cnt [5];
  logic [4:0]      accept, press;

  always_comb begin
    for (int i = 0; i < 5; i++)
      accept[i] = (sync2[i] != dbc[i]) && (db_cnt[i] == DB_W'(DB_CYCLES - 1));
    press = accept & sync2 & ~dbc;
  end

  // NOTE: the counter array is tiny and lives in flops, so every element is reset explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      dbc   <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving two real flop stages.
      sync1 <= bus.btn_in;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == dbc[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          db_cnt[i] <= '0;
          dbc[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------- move events: [0]=up [1]=down [2]=left [3]=right ----------------
  logic [3:0] mv_ev;

`ifdef POS_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt [4];
  logic [3:0]       rpt_armed, rpt_ev;

  // First repeat waits RPT_DELAY cycles of held level, later ones RPT_PERIOD.
  always_comb begin
    for (int i = 0; i < 4; i++)
      rpt_ev[i] = dbc[i] && (rpt_armed[i] ? (rpt_cnt[i] == RPT_W'(RPT_PERIOD - 1))
                                          : (rpt_cnt[i] == RPT_W'(RPT_DELAY - 1)));
    mv_ev = press[3:0] | rpt_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_armed <= '0;
      for (int i = 0; i < 4; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!dbc[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b0;
        end else if (rpt_ev[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_armed[i] <= 1'b1;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign mv_ev = press[3:0];
`endif

  // ---------------- position accumulation ----------------
  function automatic logic [7:0] step_up(input logic [7:0] v, input logic [7:0] lim);
    logic [8:0] s;
    s = {1'b0, v} + STEP_9;
    return (s > {1'b0, lim}) ? lim : s[7:0];
  endfunction

  function automatic logic [7:0] step_dn(input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, v} - STEP_9;
    return ({1'b0, v} < STEP_9) ? 8'd0 : s[7:0];
  endfunction

  logic [7:0] x, y, x_nxt, y_nxt;
  logic       sel, sel_nxt;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    x_nxt   = x;
    y_nxt   = y;
    sel_nxt = sel;
    if (press[4]) begin
      x_nxt   = X_INIT_B;
      y_nxt   = Y_INIT_B;
      sel_nxt = ~sel;
    end else begin
      if (mv_ev[0] && !mv_ev[1])      y_nxt = step_up(y, Y_MAX_B);
      else if (mv_ev[1] && !mv_ev[0]) y_nxt = step_dn(y);
      if (mv_ev[3] && !mv_ev[2])      x_nxt = step_up(x, X_MAX_B);
      else if (mv_ev[2] && !mv_ev[3]) x_nxt = step_dn(x);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= X_INIT_B;
      y   <= Y_INIT_B;
      sel <= 1'b0;
    end else begin
      x   <= x_nxt;
      y   <= y_nxt;
      sel <= sel_nxt;
    end
  end

  // ---------------- publishing ----------------
  logic       xlim, ylim;
  logic [7:0] status_int;
  logic [7:0] x_pub, y_pub, st_pub;
  logic       upd;

  assign xlim       = (x == 8'd0) || (x == X_MAX_B);
  assign ylim       = (y == 8'd0) || (y == Y_MAX_B);
  assign status_int = {sel, ylim, xlim, dbc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pub  <= X_INIT_B;
      y_pub  <= Y_INIT_B;
      st_pub <= ST_RST;
      upd    <= 1'b0;
    end else begin
      upd <= !bus.hold && ({x, y, status_int} != {x_pub, y_pub, st_pub});
      if (!bus.hold) begin
        x_pub  <= x;
        y_pub  <= y;
        st_pub <= status_int;
      end
    end
  end

  assign bus.x_pos  = x_pub;
  assign bus.y_pos  = y_pub;
  assign bus.status = st_pub;
  assign bus.update = upd;

endmodule

// File: tb/tb_pos_tracker.sv
// Directed bench for pos_tracker with DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge before changing.
module tb_pos_tracker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pos_if bus ();

  pos_tracker #(
    .DB_CYCLES (4),
    .RPT_DELAY (20),
    .RPT_PERIOD(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int upd_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (bus.update) upd_cnt++;
  end

  typedef struct {
    logic [4:0] btn;
    int         n;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] st;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b);
    bus.btn_in = b;
    cyc(8);
    bus.btn_in = 5'h00;
    cyc(8);
  endtask

  task automatic check_pub(input string name, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] st);
    check({name, " x"}, bus.x_pos, x);
    check({name, " y"}, bus.y_pos, y);
    check({name, " st"}, bus.status, st);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    // positional records: btn, presses, expected x, y, status after release
    tbl[0] = '{5'h08, 90,  8'd159, 8'd60, 8'h20};  // right saturates at X_MAX
    tbl[1] = '{5'h08, 1,   8'd159, 8'd60, 8'h20};  // further right stays
    tbl[2] = '{5'h04, 1,   8'd158, 8'd60, 8'h00};
    tbl[3] = '{5'h01, 2,   8'd158, 8'd62, 8'h00};
    tbl[4] = '{5'h02, 3,   8'd158, 8'd59, 8'h00};
    tbl[5] = '{5'h02, 70,  8'd158, 8'd0,  8'h40};  // down saturates at 0
    tbl[6] = '{5'h01, 1,   8'd158, 8'd1,  8'h00};
    tbl[7] = '{5'h04, 160, 8'd0,   8'd1,  8'h20};  // left saturates at 0

    bus.btn_in = 5'h00;
    bus.hold   = 1'b0;
    rst_n      = 1'b0;

    // reset state
    #12;
    check_pub("reset", 8'd80, 8'd60, 8'h00);
    check("reset upd", bus.update, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3);

    // right press latency: published change exactly at edge 7
    bus.btn_in = 5'h08;
    cyc(6);
    check("lat e6 x", bus.x_pos, 8'd80);
    check("lat e6 upd", bus.update, 1'b0);
    cyc(1);
    check("lat e7 x", bus.x_pos, 8'd81);
    check("lat e7 upd", bus.update, 1'b1);
    check("lat e7 st", bus.status, 8'h08);
    cyc(1);
    check("lat e8 upd", bus.update, 1'b0);
    cyc(12);
    bus.btn_in = 5'h00;
    cyc(10);
    check_pub("after right", 8'd81, 8'd60, 8'h00);

    // 3-cycle glitch is rejected
    bus.btn_in = 5'h08;
    cyc(3);
    bus.btn_in = 5'h00;
    cyc(12);
    check_pub("glitch", 8'd81, 8'd60, 8'h00);

    // table-driven press sequences
    for (int i = 0; i < $size(tbl); i++) begin
      repeat (tbl[i].n) press(tbl[i].btn);
      check_pub($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].st);
    end

    // left+right together cancel; both debounced levels visible
    bus.btn_in = 5'h0C;
    cyc(8);
    check("lr x", bus.x_pos, 8'd0);
    check("lr st", bus.status, 8'h2C);
    bus.btn_in = 5'h00;
    cyc(10);
    check_pub("lr rel", 8'd0, 8'd1, 8'h20);

    // moves then centre
    press(5'h08);
    press(5'h01);
    check_pub("pre centre", 8'd1, 8'd2, 8'h00);
    press(5'h10);
    check_pub("centre", 8'd80, 8'd60, 8'h80);

    // hold freezes published bytes; release publishes once
    bus.hold = 1'b1;
    cyc(1);
    upd_cnt = 0;
    press(5'h01);
    press(5'h01);
    check("hold y", bus.y_pos, 8'd60);
    check("hold upd cnt", upd_cnt, 0);
    bus.hold = 1'b0;
    cyc(1);
    check("unhold y", bus.y_pos, 8'd62);
    check("unhold upd", bus.update, 1'b1);
    cyc(3);
    check("unhold pulses", upd_cnt, 1);
    check_pub("unhold", 8'd80, 8'd62, 8'h80);

    // reset mid-debounce, button still held at release
    press(5'h08);
    check_pub("pre rst", 8'd81, 8'd62, 8'h80);
    bus.btn_in = 5'h08;
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    check_pub("mid rst", 8'd80, 8'd60, 8'h00);
    check("mid rst upd", bus.update, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6);
    check("rerun e6 x", bus.x_pos, 8'd80);
    cyc(1);
    check("rerun e7 x", bus.x_pos, 8'd81);
    bus.btn_in = 5'h00;
    cyc(10);
    check_pub("rerun rel", 8'd81, 8'd60, 8'h00);

`ifdef POS_AUTOREPEAT_EN
    // press at edge 7, repeats published at edges 27, 35, 43, 51
    do_reset();
    bus.btn_in = 5'h08;
    cyc(43);
    check("rpt e43 x", bus.x_pos, 8'd84);
    cyc(7);
    check("rpt e50 x", bus.x_pos, 8'd84);
    cyc(1);
    check("rpt e51 x", bus.x_pos, 8'd85);
    bus.btn_in = 5'h00;
    cyc(10);
`else
    // without auto-repeat a long hold gives one move only
    do_reset();
    bus.btn_in = 5'h08;
    cyc(60);
    check("norpt x", bus.x_pos, 8'd81);
    bus.btn_in = 5'h00;
    cyc(10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
